// File: rtl/micro_pipe_tracker_if.sv
// Bus bundle for micro_pipe_tracker: advance controls, incoming summary,
// per-stage state view, occupancy and the two producer query ports.
interface micro_pipe_tracker_if #(
  parameter int STAGES = 2,
  parameter int TYPE_W = 6,
  parameter int DEST_W = 5,
  parameter int SEL_W  = (STAGES > 1) ? $clog2(STAGES) : 1,
  parameter int OCC_W  = $clog2(STAGES + 1)
);
  logic                     freeze;
  logic                     stall;
  logic [STAGES-1:0]        flush_mask;
  logic                     in_valid;
  logic [TYPE_W-1:0]        in_type;
  logic [DEST_W-1:0]        in_dest;
  logic                     in_wb;
  logic [STAGES-1:0]        st_valid;
  logic [STAGES*TYPE_W-1:0] st_type;
  logic [STAGES*DEST_W-1:0] st_dest;
  logic [STAGES-1:0]        st_wb;
  logic [OCC_W-1:0]         occupancy;
  logic [DEST_W-1:0]        src_a;
  logic [DEST_W-1:0]        src_b;
  logic                     hit_a;
  logic                     hit_b;
  logic [SEL_W-1:0]         sel_a;
  logic [SEL_W-1:0]         sel_b;

  modport master (
    output freeze, stall, flush_mask, in_valid, in_type, in_dest, in_wb, src_a, src_b,
    input  st_valid, st_type, st_dest, st_wb, occupancy, hit_a, hit_b, sel_a, sel_b
  );

  modport slave (
    input  freeze, stall, flush_mask, in_valid, in_type, in_dest, in_wb, src_a, src_b,
    output st_valid, st_type, st_dest, st_wb, occupancy, hit_a, hit_b, sel_a, sel_b
  );
endinterface

// File: rtl/micro_pipe_tracker.sv
// In-flight micro-op summary pipeline with freeze/stall/flush control and
// youngest-producer lookup for forwarding and hazard detection.
module micro_pipe_tracker #(
  parameter int STAGES = 2,
  parameter int TYPE_W = 6,
  parameter int DEST_W = 5,
  parameter int SEL_W  = (STAGES > 1) ? $clog2(STAGES) : 1,
  parameter int OCC_W  = $clog2(STAGES + 1)
) (
  input logic                 clk,
  input logic                 rst,
  micro_pipe_tracker_if.slave bus
);

  logic [STAGES-1:0]             r_valid, w_nvalid;
  logic [STAGES-1:0][TYPE_W-1:0] r_type,  w_ntype;
  logic [STAGES-1:0][DEST_W-1:0] r_dest,  w_ndest;
  logic [STAGES-1:0]             r_wb,    w_nwb;
  logic [OCC_W-1:0]              r_occ,   w_nocc;
  logic                          w_load;

  // A rejected or stalled input collapses to an all-zero bubble, never its raw fields.
  assign w_load = bus.in_valid & ~bus.stall;

  always_comb begin
    w_nvalid = r_valid;
    w_ntype  = r_type;
    w_ndest  = r_dest;
    w_nwb    = r_wb;
    if (!bus.freeze) begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        w_nvalid[k] = r_valid[k-1];
        w_ntype[k]  = r_type[k-1];
        w_ndest[k]  = r_dest[k-1];
        w_nwb[k]    = r_wb[k-1];
      end
      w_nvalid[0] = w_load;
      w_ntype[0]  = w_load ? bus.in_type : '0;
      w_ndest[0]  = w_load ? bus.in_dest : '0;
      w_nwb[0]    = w_load & bus.in_wb;
    end
    for (int k = 0; k < STAGES; k++) begin
      if (bus.flush_mask[k]) begin
        w_nvalid[k] = 1'b0;
        w_ntype[k]  = '0;
        w_ndest[k]  = '0;
        w_nwb[k]    = 1'b0;
      end
    end
  end

  // Occupancy is computed from next state so it can be registered alongside it.
  always_comb begin
    w_nocc = '0;
    for (int k = 0; k < STAGES; k++) w_nocc = w_nocc + OCC_W'(w_nvalid[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_type  <= '0;
      r_dest  <= '0;
      r_wb    <= '0;
      r_occ   <= '0;
    end else begin
      r_valid <= w_nvalid;
      r_type  <= w_ntype;
      r_dest  <= w_ndest;
      r_wb    <= w_nwb;
      r_occ   <= w_nocc;
    end
  end

  assign bus.st_valid  = r_valid;
  assign bus.st_type   = r_type;
  assign bus.st_dest   = r_dest;
  assign bus.st_wb     = r_wb;
  assign bus.occupancy = r_occ;

  // Scan oldest to youngest so the last (lowest) match wins.
  always_comb begin
    bus.hit_a = 1'b0;
    bus.sel_a = '0;
    bus.hit_b = 1'b0;
    bus.sel_b = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (r_valid[k] && r_wb[k] && (bus.src_a != '0) && (r_dest[k] == bus.src_a)) begin
        bus.hit_a = 1'b1;
        bus.sel_a = SEL_W'(k);
      end
      if (r_valid[k] && r_wb[k] && (bus.src_b != '0) && (r_dest[k] == bus.src_b)) begin
        bus.hit_b = 1'b1;
        bus.sel_b = SEL_W'(k);
      end
    end
  end

endmodule

// File: doc/micro_pipe_tracker.md
# micro_pipe_tracker

Parametrised micro-op summary pipeline for the in-order core. It carries one summary per in-flight instruction from the decode boundary through STAGES downstream stages: type, write-back destination, write-enable and valid. It generalises the fixed two-stage EX/MEM transfer line with configurable depth and field widths, per-stage flush, whole-pipe freeze, occupancy count, and two built-in forwarding/hazard query ports. The hazard unit and the write-back mux use it to find the youngest in-flight producer of a source register.

## Interface
Parameters:
- STAGES, 2, number of tracked stages (≥1); stage 0 is youngest (EX), stage STAGES-1 is oldest.
- TYPE_W, 6, instruction-type field width; type code 0 is reserved for a bubble.
- DEST_W, 5, destination register index width; register 0 never matches a query.
- SEL_W, max(1, clog2(STAGES)), width of the stage-select outputs.

Ports (clock and reset first):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hold every stage (memory wait).
- stall  in  1  insert a bubble at stage 0 while older stages advance.
- flush_mask  in  STAGES  bit k forces stage k to a bubble on this edge.
- in_valid  in  1  incoming summary present.
- in_type  in  TYPE_W  incoming instruction type.
- in_dest  in  DEST_W  incoming write-back destination.
- in_wb  in  1  incoming instruction writes a register.
- st_valid  out  STAGES  per-stage valid.
- st_type  out  STAGES*TYPE_W  stage k at bits [k*TYPE_W +: TYPE_W].
- st_dest  out  STAGES*DEST_W  stage k at bits [k*DEST_W +: DEST_W].
- st_wb  out  STAGES  per-stage write-enable.
- occupancy  out  clog2(STAGES+1)  number of valid stages.
- src_a, src_b  in  DEST_W  query register indices.
- hit_a, hit_b  out  1  an in-flight producer of the queried register exists.
- sel_a, sel_b  out  SEL_W  index of the youngest matching stage.

## Operation
- Bubble: valid=0, type=0, dest=0, wb=0. Every stored entry is either a bubble or a valid entry; no X is ever stored.
- Update priority on each edge, highest first:
  - rst: all stages become bubbles.
  - freeze=1: every stage holds. Then any stage with flush_mask[k]=1 becomes a bubble. stall and the input are ignored.
  - Otherwise shift:
    - Stage k gets the old value of stage k-1 (k≥1). The old stage STAGES-1 retires and is discarded.
    - Stage 0 gets the input summary if stall=0 and in_valid=1.
    - Stage 0 gets a bubble if stall=1 or in_valid=0.
    - Then any stage with flush_mask[k]=1 becomes a bubble.
- An input with in_valid=0 is stored as a bubble, whatever values sit on in_type, in_dest and in_wb.
- Query for src_a (src_b is identical and independent):
  - Stage k matches when st_valid[k]=1, st_wb[k]=1, st_dest[k]==src_a and src_a≠0.
  - hit_a = OR of all matches.
  - sel_a = lowest matching k, so the youngest producer wins.
  - sel_a = 0 when there is no hit.
- occupancy = popcount(st_valid).

## Timing
- All st_* outputs and occupancy are registered. They reset to 0 and are valid from the first edge after rst is released.
- Input to stage 0 latency: 1 cycle. Input to stage k latency: k+1 cycles, absent freeze.
- hit/sel are combinational from registered state and src_*, with 0-cycle latency. They must not depend on same-cycle in_* values, so there is no input bypass.
- Simultaneous stall and flush_mask[0]: stage 0 becomes a bubble (same result either way).
- Simultaneous freeze and stall: freeze wins and nothing advances.
- rst asserted mid-operation clears everything on that edge. rst overrides freeze and flush.
- STAGES=1: the shift reduces to a stage 0 load, and sel_* is constant 0.

## Test plan
- Reset then idle: assert rst for 2 cycles with in_valid=1 → all outputs 0, occupancy=0. After release, with no input, the state stays all-bubble.
- Shift, STAGES=2: inject type=3 dest=7 wb=1, then type=5 dest=9 wb=1 → on the second edge stage0=(5,9) and stage1=(3,7), occupancy=2. Third edge with in_valid=0 → stage1=(5,9), stage0 bubble.
- Stall: pipe holds (3,7) in stage 0, assert stall with in_valid=1 dest=4 → next cycle stage1=(3,7), stage 0 bubble, and dest 4 is not captured.
- Freeze plus flush: stages (5,9)/(3,7), freeze=1, flush_mask=2'b10 → stage0=(5,9) held, stage1 bubble, occupancy=1.
- Forwarding priority: stage0 dest=7 wb=1 and stage1 dest=7 wb=1, src_a=7 → hit_a=1, sel_a=0. Flush stage 0 → next cycle sel_a=1. src_a=0 → hit_a=0. Stage with wb=0 and dest=7 → no hit.
- STAGES=4 sweep: 6 consecutive valid inputs → occupancy goes 1,2,3,4,4,4, and each summary exits at stage 3 after 4 cycles.
